// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB. Allocates at issue, captures ALU/LSB
// results, retires in program order and flushes the pipeline on a mispredict.
//
// Ports:
//   clk, reset (async, active-low), ready (global enable)
//   issue_*  : allocate request in, issue_robpos/full out
//   alu_*    : ALU writeback (value + actual branch outcome)
//   lsb_*    : load/store writeback
//   q1_*/q2_*: combinational operand lookup with same-cycle bypass
//   commit_* : regfile unlock strobe (registered)
//   store_*  : retired-store notification (registered)
//   clear, redirect_pc : flush pulse and fetch target (registered)
// Optional: define ROB_PERF_CNT_EN to add perf_commits / perf_flushes.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [1:0]        issue_kind,
    input  logic              issue_pred_taken,
    input  logic [DATA_W-1:0] issue_alt_pc,
    output logic [ROB_W-1:0]  issue_robpos,
    output logic              full,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_robpos,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              alu_taken,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_robpos,
    input  logic [DATA_W-1:0] lsb_val,
    input  logic [ROB_W-1:0]  q1_robpos,
    output logic              q1_ready,
    output logic [DATA_W-1:0] q1_val,
    input  logic [ROB_W-1:0]  q2_robpos,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q2_val,
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_rd,
    output logic [ROB_W-1:0]  commit_robpos,
    output logic [DATA_W-1:0] commit_val,
    output logic              store_commit,
    output logic [ROB_W-1:0]  store_robpos,
    output logic              clear,
    output logic [DATA_W-1:0] redirect_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_flushes
`endif
);

    localparam logic [ROB_W:0] FULL_CNT = ROB_SIZE[ROB_W:0];

    localparam logic [1:0] K_REG    = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_STORE  = 2'd2;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] done;
    logic [ROB_SIZE-1:0] pred_q;
    logic [ROB_SIZE-1:0] taken_q;
    logic [1:0]          kind_q [ROB_SIZE];
    logic [REG_W-1:0]    rd_q   [ROB_SIZE];
    logic [DATA_W-1:0]   val_q  [ROB_SIZE];
    logic [DATA_W-1:0]   alt_q  [ROB_SIZE];

    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [ROB_W:0]   count;

    logic do_alloc;
    logic do_commit;
    logic alu_hit;
    logic lsb_hit;
    logic mispred;

    assign full         = (count == FULL_CNT);
    assign issue_robpos = tail;

    assign do_alloc  = issue_valid && !full && !clear;
    assign do_commit = busy[head] && done[head] && !clear;
    assign alu_hit   = alu_valid && !clear && busy[alu_robpos];
    assign lsb_hit   = lsb_valid && !clear && busy[lsb_robpos];
    assign mispred   = do_commit && (kind_q[head] == K_BRANCH)
                       && (taken_q[head] != pred_q[head]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            done          <= '0;
            pred_q        <= '0;
            taken_q       <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_robpos <= '0;
            commit_val    <= '0;
            store_commit  <= 1'b0;
            store_robpos  <= '0;
            clear         <= 1'b0;
            redirect_pc   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                kind_q[i] <= '0;
                rd_q[i]   <= '0;
                val_q[i]  <= '0;
                alt_q[i]  <= '0;
            end
        end else if (ready) begin
            if (clear) begin
                // Flush cycle: everything in flight is younger than the
                // mispredicted branch, so the whole buffer is discarded.
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                busy          <= '0;
                done          <= '0;
                commit_valid  <= 1'b0;
                commit_rd     <= '0;
                commit_robpos <= '0;
                commit_val    <= '0;
                store_commit  <= 1'b0;
                store_robpos  <= '0;
                clear         <= 1'b0;
                redirect_pc   <= '0;
            end else begin
                // LSB first so an ALU write to the same slot overrides it.
                if (lsb_hit) begin
                    val_q[lsb_robpos] <= lsb_val;
                    done[lsb_robpos]  <= 1'b1;
                end
                if (alu_hit) begin
                    val_q[alu_robpos]   <= alu_val;
                    taken_q[alu_robpos] <= alu_taken;
                    done[alu_robpos]    <= 1'b1;
                end

                if (do_commit) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + 1'b1;
                end

                // tail can only equal a busy head when full, which blocks
                // allocation, so this never collides with the commit above.
                if (do_alloc) begin
                    busy[tail]    <= 1'b1;
                    done[tail]    <= 1'b0;
                    kind_q[tail]  <= issue_kind;
                    rd_q[tail]    <= issue_rd;
                    pred_q[tail]  <= issue_pred_taken;
                    alt_q[tail]   <= issue_alt_pc;
                    taken_q[tail] <= 1'b0;
                    val_q[tail]   <= '0;
                    tail          <= tail + 1'b1;
                end

                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase

                commit_valid  <= do_commit;
                commit_robpos <= do_commit ? head : '0;
                commit_val    <= do_commit ? val_q[head] : '0;
                commit_rd     <= (do_commit && kind_q[head] == K_REG)
                                 ? rd_q[head] : '0;

                store_commit  <= do_commit && (kind_q[head] == K_STORE);
                store_robpos  <= (do_commit && kind_q[head] == K_STORE)
                                 ? head : '0;

                clear         <= mispred;
                redirect_pc   <= mispred ? alt_q[head] : '0;
            end
        end
    end

    // Operand lookup: an in-flight writeback is forwarded before it lands.
    always_comb begin
        q1_ready = 1'b0;
        q1_val   = '0;
        if (alu_valid && alu_robpos == q1_robpos) begin
            q1_ready = 1'b1;
            q1_val   = alu_val;
        end else if (lsb_valid && lsb_robpos == q1_robpos) begin
            q1_ready = 1'b1;
            q1_val   = lsb_val;
        end else if (done[q1_robpos]) begin
            q1_ready = 1'b1;
            q1_val   = val_q[q1_robpos];
        end
    end

    always_comb begin
        q2_ready = 1'b0;
        q2_val   = '0;
        if (alu_valid && alu_robpos == q2_robpos) begin
            q2_ready = 1'b1;
            q2_val   = alu_val;
        end else if (lsb_valid && lsb_robpos == q2_robpos) begin
            q2_ready = 1'b1;
            q2_val   = lsb_val;
        end else if (done[q2_robpos]) begin
            q2_ready = 1'b1;
            q2_val   = val_q[q2_robpos];
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else if (ready) begin
            if (do_commit) perf_commits <= perf_commits + 32'd1;
            if (mispred)   perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic checked
// against an in-order queue model of the reorder buffer.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_kind;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic [3:0]  issue_robpos;
    logic        full;
    logic        alu_valid;
    logic [3:0]  alu_robpos;
    logic [31:0] alu_val;
    logic        alu_taken;
    logic        lsb_valid;
    logic [3:0]  lsb_robpos;
    logic [31:0] lsb_val;
    logic [3:0]  q1_robpos;
    logic        q1_ready;
    logic [31:0] q1_val;
    logic [3:0]  q2_robpos;
    logic        q2_ready;
    logic [31:0] q2_val;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_robpos;
    logic [31:0] commit_val;
    logic        store_commit;
    logic [3:0]  store_robpos;
    logic        clear;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .ready(ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_kind(issue_kind), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .issue_robpos(issue_robpos),
        .full(full),
        .alu_valid(alu_valid), .alu_robpos(alu_robpos),
        .alu_val(alu_val), .alu_taken(alu_taken),
        .lsb_valid(lsb_valid), .lsb_robpos(lsb_robpos), .lsb_val(lsb_val),
        .q1_robpos(q1_robpos), .q1_ready(q1_ready), .q1_val(q1_val),
        .q2_robpos(q2_robpos), .q2_ready(q2_ready), .q2_val(q2_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_robpos(commit_robpos), .commit_val(commit_val),
        .store_commit(store_commit), .store_robpos(store_robpos),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: entries live in program order from m_head for m_size
    // slots; a slot is in flight iff its distance from head is < m_size.
    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  kind;
        logic        pred;
        logic [31:0] alt;
        logic        done;
        logic [31:0] val;
        logic        taken;
    } ent_t;

    ent_t m_ent[16];
    int   m_head;
    int   m_size;
    bit   m_clear;

    bit          e_cv, e_sc, e_clr;
    logic [4:0]  e_crd;
    logic [3:0]  e_cpos, e_spos;
    logic [31:0] e_cval, e_rpc;

    function automatic bit m_live(int idx);
        return ((idx - m_head + 16) % 16) < m_size;
    endfunction

    task automatic model_reset();
        m_head = 0; m_size = 0; m_clear = 0;
        e_cv = 0; e_sc = 0; e_clr = 0;
        for (int i = 0; i < 16; i++) m_ent[i].done = 0;
    endtask

    task automatic model_edge();
        ent_t h;
        bit   com;
        int   pre_size;
        int   tl;
        if (!ready) return;
        if (m_clear) begin
            m_head = 0; m_size = 0; m_clear = 0;
            e_cv = 0; e_sc = 0; e_clr = 0;
            return;
        end
        pre_size = m_size;
        tl = (m_head + m_size) % 16;
        h = m_ent[m_head];
        com = (m_size > 0) && h.done;
        if (lsb_valid && m_live(int'(lsb_robpos))) begin
            m_ent[lsb_robpos].val  = lsb_val;
            m_ent[lsb_robpos].done = 1;
        end
        if (alu_valid && m_live(int'(alu_robpos))) begin
            m_ent[alu_robpos].val   = alu_val;
            m_ent[alu_robpos].taken = alu_taken;
            m_ent[alu_robpos].done  = 1;
        end
        e_cv   = com;
        e_cpos = 4'(m_head);
        e_crd  = (h.kind == 2'd0) ? h.rd : 5'd0;
        e_cval = h.val;
        e_sc   = com && (h.kind == 2'd2);
        e_spos = 4'(m_head);
        e_clr  = com && (h.kind == 2'd1) && (h.taken != h.pred);
        e_rpc  = h.alt;
        m_clear = e_clr;
        if (com) begin
            m_head = (m_head + 1) % 16;
            m_size--;
        end
        if (issue_valid && pre_size < 16) begin
            m_ent[tl].rd    = issue_rd;
            m_ent[tl].kind  = issue_kind;
            m_ent[tl].pred  = issue_pred_taken;
            m_ent[tl].alt   = issue_alt_pc;
            m_ent[tl].done  = 0;
            m_ent[tl].val   = 0;
            m_ent[tl].taken = 0;
            m_size++;
        end
    endtask

    task automatic exp_q(input logic [3:0] q, output logic r,
                         output logic [31:0] v);
        r = 0; v = 0;
        if (alu_valid && alu_robpos == q) begin r = 1; v = alu_val; end
        else if (lsb_valid && lsb_robpos == q) begin r = 1; v = lsb_val; end
        else if (m_live(int'(q)) && m_ent[q].done) begin
            r = 1; v = m_ent[q].val;
        end
    endtask

    task automatic check_comb();
        logic r;
        logic [31:0] v;
        check("full", full, m_size == 16);
        check("issue_robpos", issue_robpos, (m_head + m_size) % 16);
        exp_q(q1_robpos, r, v);
        check("q1_ready", q1_ready, r);
        check("q1_val", q1_val, v);
        exp_q(q2_robpos, r, v);
        check("q2_ready", q2_ready, r);
        check("q2_val", q2_val, v);
    endtask

    task automatic check_regs();
        check("commit_valid", commit_valid, e_cv);
        if (e_cv) begin
            check("commit_rd", commit_rd, e_crd);
            check("commit_robpos", commit_robpos, e_cpos);
            check("commit_val", commit_val, e_cval);
        end
        check("store_commit", store_commit, e_sc);
        if (e_sc) check("store_robpos", store_robpos, e_spos);
        check("clear", clear, e_clr);
        if (e_clr) check("redirect_pc", redirect_pc, e_rpc);
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        ready = 1; issue_valid = 0; issue_rd = 0; issue_kind = 0;
        issue_pred_taken = 0; issue_alt_pc = 0;
        alu_valid = 0; alu_robpos = 0; alu_val = 0; alu_taken = 0;
        lsb_valid = 0; lsb_robpos = 0; lsb_val = 0;
        q1_robpos = 0; q2_robpos = 0;
    endtask

    task automatic issue(input logic [1:0] k, input logic [4:0] rd,
                         input logic p, input logic [31:0] alt);
        idle();
        issue_valid = 1; issue_kind = k; issue_rd = rd;
        issue_pred_taken = p; issue_alt_pc = alt;
        step();
    endtask

    task automatic alu_wb(input logic [3:0] pos, input logic [31:0] v,
                          input logic t);
        idle();
        alu_valid = 1; alu_robpos = pos; alu_val = v; alu_taken = t;
        step();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        idle();
        #3 reset = 0;
        #1;
        check("rst_full", full, 1'b0);
        check("rst_issue_robpos", issue_robpos, 4'd0);
        check("rst_commit_valid", commit_valid, 1'b0);
        check("rst_clear", clear, 1'b0);
        check("rst_store_commit", store_commit, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    function automatic logic [3:0] pick_idx();
        if (m_size > 0 && ($urandom % 5) != 0)
            return 4'((m_head + int'($urandom % m_size)) % 16);
        return 4'($urandom % 16);
    endfunction

    initial begin
        idle();
        reset = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        reset = 1;

        // Reset in the middle of operation with five entries in flight.
        for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 1), 0, 0);
        do_reset();
        idle();
        #1 check("post_rst_robpos", issue_robpos, 4'd0);
        @(negedge clk);

        // Out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 1), 0, 0);
        alu_wb(4'd2, 32'h30, 0);
        alu_wb(4'd1, 32'h20, 0);
        alu_wb(4'd0, 32'h10, 0);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ev;
            ev = 32'h10 * (i + 1);
            idle();
            step();
            check("order_valid", commit_valid, 1'b1);
            check("order_rd", commit_rd, 5'(i + 1));
            check("order_val", commit_val, ev);
        end

        // Fill to 16, overflow request ignored, then wrap.
        do_reset();
        for (int i = 0; i < 16; i++) issue(2'd0, 5'd7, 0, 0);
        check("fill_full", full, 1'b1);
        check("fill_robpos", issue_robpos, 4'd0);
        issue(2'd0, 5'd8, 0, 0);
        check("ovf_full", full, 1'b1);
        idle();
        lsb_valid = 1; lsb_robpos = 0; lsb_val = 32'h77;
        step();
        idle();
        step();
        check("wrap_full", full, 1'b0);
        check("wrap_robpos", issue_robpos, 4'd0);
        issue(2'd0, 5'd9, 0, 0);
        check("wrap_robpos2", issue_robpos, 4'd1);
        check("wrap_full2", full, 1'b1);

        // Mispredicted branch at robpos 4 with two younger entries.
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 0, 0);
        issue(2'd1, 5'd0, 0, 32'h1000);
        issue(2'd0, 5'd5, 0, 0);
        issue(2'd0, 5'd6, 0, 0);
        for (int i = 0; i < 4; i++) alu_wb(4'(i), 32'(i), 0);
        alu_wb(4'd4, 32'h44, 1);
        idle();
        step();
        check("br_commit_pos", commit_robpos, 4'd4);
        check("br_clear", clear, 1'b1);
        check("br_redirect", redirect_pc, 32'h1000);
        idle();
        alu_valid = 1; alu_robpos = 5; alu_val = 32'h55;
        issue_valid = 1;
        step();
        check("br_clear_drop", clear, 1'b0);
        check("br_robpos", issue_robpos, 4'd0);
        idle();
        q1_robpos = 5;
        #1 check("br_young_ready", q1_ready, 1'b0);
        @(negedge clk);

        // Same-cycle bypass with ALU priority.
        do_reset();
        for (int i = 0; i < 8; i++) issue(2'd0, 5'd3, 0, 0);
        idle();
        q1_robpos = 7;
        alu_valid = 1; alu_robpos = 7; alu_val = 32'hDEAD;
        #1;
        check("byp_ready", q1_ready, 1'b1);
        check("byp_val", q1_val, 32'hDEAD);
        lsb_valid = 1; lsb_robpos = 7; lsb_val = 32'hBEEF;
        #1;
        check("byp_prio_val", q1_val, 32'hDEAD);
        @(negedge clk);
        step();

        // Store retirement, then a three-cycle stall.
        do_reset();
        issue(2'd2, 5'd9, 0, 0);
        idle();
        lsb_valid = 1; lsb_robpos = 0; lsb_val = 32'h5;
        step();
        idle();
        step();
        check("st_commit", store_commit, 1'b1);
        check("st_robpos", store_robpos, 4'd0);
        check("st_rd", commit_rd, 5'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            ready = 0;
            issue_valid = 1;
            step();
            check("hold_store", store_commit, 1'b1);
            check("hold_commit", commit_valid, 1'b1);
            check("hold_robpos", issue_robpos, 4'd1);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle();
            ready = ($urandom % 100) < 92;
            issue_valid = ($urandom % 100) < 55;
            r = int'($urandom % 10);
            issue_kind = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 :
                         (r == 7) ? 2'd2 : 2'd3;
            issue_rd = 5'($urandom);
            issue_pred_taken = 1'($urandom);
            issue_alt_pc = $urandom;
            alu_valid = ($urandom % 100) < 40;
            alu_robpos = pick_idx();
            alu_val = $urandom;
            if (m_live(int'(alu_robpos)) && m_ent[alu_robpos].kind == 2'd1)
                alu_taken = (($urandom % 6) == 0) ? ~m_ent[alu_robpos].pred
                                                  : m_ent[alu_robpos].pred;
            else
                alu_taken = 1'($urandom);
            lsb_valid = ($urandom % 100) < 30;
            lsb_robpos = (($urandom % 4) == 0) ? alu_robpos : pick_idx();
            lsb_val = $urandom;
            q1_robpos = (($urandom % 3) == 0) ? alu_robpos : 4'($urandom);
            q2_robpos = (($urandom % 3) == 0) ? lsb_robpos : 4'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer between issue/decode and the register file.
- Allocates one entry per issued instruction and captures results from the ALU and load/store writeback ports.
- Retires entries strictly in program order, one per cycle, driving the regfile unlock port with rd, robpos and value.
- Detects branch mispredictions at commit, pulses a pipeline-wide clear and supplies the redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries; power of two.
- ROB_W, 4, entry index width; log2(ROB_SIZE).
- DATA_W, 32, data and PC width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset. reset==0 clears all state immediately.
- ready  in  1  global enable; when 0, all state holds.
- issue_valid  in  1  allocate request.
- issue_rd  in  REG_W  destination register; 0 means no writeback.
- issue_kind  in  2  0=reg-write, 1=branch, 2=store, 3=other.
- issue_pred_taken  in  1  predicted branch direction.
- issue_alt_pc  in  DATA_W  redirect target if the branch prediction is wrong.
- issue_robpos  out  ROB_W  index to be allocated (current tail).
- full  out  1  count==ROB_SIZE.
- alu_valid  in  1  ALU result valid.
- alu_robpos  in  ROB_W  ALU result entry index.
- alu_val  in  DATA_W  ALU result value.
- alu_taken  in  1  actual branch outcome.
- lsb_valid  in  1  load/store result valid.
- lsb_robpos  in  ROB_W  load/store result entry index.
- lsb_val  in  DATA_W  load/store result value.
- q1_robpos  in  ROB_W  operand lookup 1.
- q1_ready  out  1  lookup 1 entry has its result.
- q1_val  out  DATA_W  lookup 1 value.
- q2_robpos  in  ROB_W  operand lookup 2.
- q2_ready  out  1  lookup 2 entry has its result.
- q2_val  out  DATA_W  lookup 2 value.
- commit_valid  out  1  regfile unlock strobe.
- commit_rd  out  REG_W  committed destination register.
- commit_robpos  out  ROB_W  committed entry index.
- commit_val  out  DATA_W  committed value.
- store_commit  out  1  head store retired; LSB may write memory.
- store_robpos  out  ROB_W  retired store entry index.
- clear  out  1  flush pulse.
- redirect_pc  out  DATA_W  fetch target, valid while clear==1.

Behaviour:
- State: per entry busy, done, kind, rd, val, pred, actual_taken, alt_pc. Pointers head and tail (ROB_W bits, wrap modulo ROB_SIZE) and count (ROB_W+1 bits).
- Reset (reset==0, asynchronous): head=tail=count=0, all busy/done=0.
  - All registered outputs 0: commit_valid, commit_rd, commit_robpos, commit_val, store_commit, store_robpos, clear, redirect_pc.
- When ready==0, nothing changes, including the registered outputs.
- Allocate on the rising edge when issue_valid && !full && !clear.
  - Entry[tail] gets busy=1, done=0 and the fields from the issue ports.
  - tail advances by 1 with wrap-around.
  - If issue_kind is 2 or 3, the entry is not done at allocation; it waits for a writeback like any other kind.
  - issue_valid while full: the request is ignored and no state changes.
- Writeback: alu_valid sets entry[alu_robpos].val=alu_val, actual_taken=alu_taken, done=1.
  - lsb_valid sets entry[lsb_robpos].val=lsb_val, done=1.
  - A writeback to a non-busy entry is ignored.
  - Both ports addressing the same index: the ALU port wins.
  - Writebacks are ignored in any cycle with clear==1.
- Commit happens at most once per edge, when entry[head] is busy && done && !clear. On that edge:
  - head advances and busy[head] is cleared.
  - commit_valid=1 for one cycle, commit_rd = rd (forced 0 when kind != 0), commit_robpos = head, commit_val = val.
  - kind==2: store_commit=1 and store_robpos=head, each for one cycle.
  - kind==1 with actual_taken != pred: clear=1 and redirect_pc=alt_pc on the same edge. The branch itself commits.
- Commit latency: a result written back at edge N commits at edge N+1 at the earliest. Commit outputs are registered and deassert the following cycle unless a new commit occurs.
- Flush: in the cycle clear==1, the next edge sets head=tail=count=0, clears all busy/done and drops clear to 0.
  - Issue, writeback and commit are all blocked during that clear cycle.
- Simultaneous allocate and commit: count is unchanged; allocation is allowed when full only if… it is not: full blocks allocation regardless of a same-cycle commit.
- Lookup (combinational): qN_ready=1 when entry[qN_robpos] is done, with qN_val = stored val.
  - Same-cycle bypass: if alu_valid or lsb_valid targets qN_robpos, qN_ready=1 and qN_val is the incoming value (ALU has priority).
  - Otherwise qN_ready=0 and qN_val=0.

Optional Feature:
- ROB_PERF_CNT_EN defined adds outputs perf_commits (32 bits) and perf_flushes (32 bits).
  - Both reset to 0 and increment on commit and on mispredict flush respectively; both wrap at 2^32.
- ROB_PERF_CNT_EN undefined: these ports and registers do not exist.

Test Plan:
- Reset low mid-operation with count=5 -> immediately count=0, full=0, commit_valid=0, clear=0. After release, issue_robpos=0.
- Issue 3 reg-writes (rd=1,2,3); writeback robpos 2,1,0 with values 0x30,0x20,0x10 -> commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles, starting the edge after robpos 0 is written.
- Issue 16 entries -> full=1. A 17th issue_valid is ignored. Then commit 1 and issue 1 -> tail wraps to index 0, issue_robpos=0.
- Branch at robpos 4 (pred=0, alt_pc=0x1000) followed by 2 younger entries; alu_taken=1 -> branch commits, clear=1 with redirect_pc=0x1000 for exactly one cycle. Next cycle count=0, and younger writebacks are ignored.
- q1_robpos=7 while alu_valid writes robpos 7 with 0xDEAD -> q1_ready=1, q1_val=0xDEAD in the same cycle. With lsb_valid simultaneously targeting 7, the ALU value still wins.
- Store at head, done -> store_commit=1, store_robpos=head, commit_valid=1 with commit_rd=0. ready=0 for 3 cycles -> all outputs and pointers hold.
